// File: rtl/seq_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_alu : registered signed ALU with valid/ready handshake, iterative MULT.
// Revision: 1.0
// ----------------------------------------------------------------------------
module seq_alu #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      in_valid_in,
  output logic                      in_ready_out,
  input  logic [2:0]                sel_in,
  input  logic [DATA_WIDTH-1:0]     a_in,
  input  logic [DATA_WIDTH-1:0]     b_in,
  output logic                      out_valid_out,
  input  logic                      out_ready_in,
  output logic [2*DATA_WIDTH-1:0]   alu_out,
  output logic                      zero_out,
  output logic                      neg_out,
  output logic                      ovf_out,
  output logic                      err_out
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] c_last_cnt = CW'(DATA_WIDTH - 1);

  localparam logic [2:0] c_op_add  = 3'b000;
  localparam logic [2:0] c_op_sub  = 3'b001;
  localparam logic [2:0] c_op_mult = 3'b010;
  localparam logic [2:0] c_op_and  = 3'b011;
  localparam logic [2:0] c_op_or   = 3'b100;
  localparam logic [2:0] c_op_xor  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         res_q, res_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic [RW-1:0]         acc_q, acc_d;
  logic [RW-1:0]         mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic                  msign_q, msign_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [RW-1:0]         w_ext_a, w_ext_b, w_new_res, w_acc_sum;
  logic                  w_upd, w_new_err;
  logic [DATA_WIDTH:0]   w_top;

  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign w_ext_a   = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
  assign w_ext_b   = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
  assign w_acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign w_top     = w_new_res[RW-1:DATA_WIDTH-1];

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    msign_d   = msign_q;
    cnt_d     = cnt_q;
    w_upd     = 1'b0;
    w_new_res = '0;
    w_new_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_in) begin
          if (sel_in == c_op_mult) begin
            state_d  = BUSY;
            acc_d    = '0;
            mcand_d  = {{DATA_WIDTH{1'b0}}, mag(a_in)};
            mplier_d = mag(b_in);
            msign_d  = a_in[DATA_WIDTH-1] ^ b_in[DATA_WIDTH-1];
            cnt_d    = '0;
          end else begin
            state_d = DONE;
            w_upd   = 1'b1;
            case (sel_in)
              c_op_add: w_new_res = w_ext_a + w_ext_b;
              c_op_sub: w_new_res = w_ext_a - w_ext_b;
              c_op_and: w_new_res = w_ext_a & w_ext_b;
              c_op_or:  w_new_res = w_ext_a | w_ext_b;
              c_op_xor: w_new_res = w_ext_a ^ w_ext_b;
              default:  w_new_err = 1'b1;
            endcase
          end
        end
      end
      BUSY: begin
        // Shift-add on magnitudes; sign is applied to the final partial sum.
        acc_d    = w_acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == c_last_cnt) begin
          state_d   = DONE;
          w_upd     = 1'b1;
          w_new_res = msign_q ? (~w_acc_sum + 1'b1) : w_acc_sum;
        end
      end
      DONE: begin
        if (out_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (w_upd) begin
      res_d  = w_new_res;
      zero_d = (w_new_res == '0);
      neg_d  = w_new_res[RW-1];
      ovf_d  = !((&w_top) || !(|w_top));
      err_d  = w_new_err;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      res_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      msign_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      msign_q  <= msign_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready_out  = (state_q == IDLE);
  assign out_valid_out = (state_q == DONE);
  assign alu_out       = res_q;
  assign zero_out      = zero_q;
  assign neg_out       = neg_q;
  assign ovf_out       = ovf_q;
  assign err_out       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_alu : directed self-checking bench for seq_alu at DATA_WIDTH = 4.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int DATA_WIDTH = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       in_valid_in = 1'b0;
  logic       in_ready_out;
  logic [2:0] sel_in = 3'b000;
  logic [3:0] a_in = 4'h0;
  logic [3:0] b_in = 4'h0;
  logic       out_valid_out;
  logic       out_ready_in = 1'b0;
  logic [7:0] alu_out;
  logic       zero_out, neg_out, ovf_out, err_out;

  int vectors = 0;
  int miscompares = 0;

  seq_alu #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .sel_in        (sel_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .alu_out       (alu_out),
    .zero_out      (zero_out),
    .neg_out       (neg_out),
    .ovf_out       (ovf_out),
    .err_out       (err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks result and flags packed as {alu, zero, neg, ovf, err}.
  task automatic chk_res(input string tag, input logic [7:0] r, input logic [3:0] f);
    chk({tag, " alu"}, {24'h0, alu_out}, {24'h0, r});
    chk({tag, " flags"}, {28'h0, zero_out, neg_out, ovf_out, err_out}, {28'h0, f});
  endtask

  task automatic chk_hs(input string tag, input logic rdy, input logic vld);
    chk({tag, " hs"}, {30'h0, in_ready_out, out_valid_out}, {30'h0, rdy, vld});
  endtask

  task automatic issue(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    in_valid_in = 1'b1;
    sel_in = s;
    a_in = a;
    b_in = b;
    tick();
    in_valid_in = 1'b0;
  endtask

  task automatic consume();
    out_ready_in = 1'b1;
    tick();
    out_ready_in = 1'b0;
    chk_hs("consume", 1'b1, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    rst_in = 1'b0;
    chk_hs("reset", 1'b1, 1'b0);
    chk_res("reset", 8'h00, 4'b0000);

    issue(3'b000, 4'd7, 4'd1);
    chk_hs("add7+1", 1'b0, 1'b1);
    chk_res("add7+1", 8'h08, 4'b0010);
    consume();

    issue(3'b001, 4'h8, 4'd1);
    chk_res("sub-8-1", 8'hF7, 4'b0110);
    consume();

    issue(3'b101, 4'd5, 4'd5);
    chk_res("xor5^5", 8'h00, 4'b1000);
    consume();

    issue(3'b010, 4'h8, 4'h8);
    for (int i = 0; i < 3; i++) begin
      chk_hs("mult busy", 1'b0, 1'b0);
      tick();
    end
    chk_hs("mult busy last", 1'b0, 1'b0);
    tick();
    chk_hs("mult done", 1'b0, 1'b1);
    chk_res("mult-8*-8", 8'h40, 4'b0010);
    consume();

    issue(3'b010, 4'hD, 4'd5);
    repeat (4) tick();
    chk_hs("mult2 done", 1'b0, 1'b1);
    chk_res("mult-3*5", 8'hF1, 4'b0110);
    consume();

    issue(3'b110, 4'd3, 4'd2);
    chk_res("illegal", 8'h00, 4'b1001);
    consume();
    issue(3'b011, 4'd3, 4'hE);
    chk_res("and3&-2", 8'h02, 4'b0000);
    consume();

    issue(3'b000, 4'hC, 4'hB);
    in_valid_in = 1'b1;
    sel_in = 3'b000;
    a_in = 4'd1;
    b_in = 4'd1;
    for (int i = 0; i < 3; i++) begin
      chk_hs("bp hold", 1'b0, 1'b1);
      chk_res("bp hold", 8'hF7, 4'b0110);
      tick();
    end
    out_ready_in = 1'b1;
    chk_hs("bp pre-release", 1'b0, 1'b1);
    tick();
    chk_hs("bp released", 1'b1, 1'b0);
    chk_res("bp released", 8'hF7, 4'b0110);
    tick();
    in_valid_in = 1'b0;
    chk_hs("bp next accept", 1'b0, 1'b1);
    chk_res("add1+1", 8'h02, 4'b0000);
    tick();
    out_ready_in = 1'b0;
    chk_hs("one-cycle present", 1'b1, 1'b0);

    issue(3'b010, 4'd3, 4'd3);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk_hs("abort", 1'b1, 1'b0);
    chk_res("abort", 8'h00, 4'b0000);
    issue(3'b000, 4'd2, 4'd3);
    chk_hs("add2+3", 1'b0, 1'b1);
    chk_res("add2+3", 8'h05, 4'b0000);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
